// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keycode decoder.
//   - scan_state_t : scan-code FSM state
//   - SC_EXT/SC_BRK: scan code set 2 prefix bytes
//   - HID_*        : HID usage codes produced on the keycode bus
//   - xlat_base/xlat_ext: set-2 make code to HID usage (0x00 when unmapped)
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } scan_state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  // Base (non-prefixed) set-2 codes
  function automatic logic [7:0] xlat_base(input logic [7:0] sc);
    logic [7:0] hid;
    case (sc)
      8'h1C:   hid = HID_A;
      8'h23:   hid = HID_D;
      8'h1B:   hid = HID_S;
      8'h1D:   hid = HID_W;
      8'h29:   hid = HID_SPACE;
      8'h5A:   hid = HID_ENTER;
      default: hid = HID_NONE;
    endcase
    return hid;
  endfunction

  // E0-prefixed set-2 codes
  function automatic logic [7:0] xlat_ext(input logic [7:0] sc);
    logic [7:0] hid;
    case (sc)
      8'h6B:   hid = HID_LEFT;
      8'h74:   hid = HID_RIGHT;
      8'h75:   hid = HID_UP;
      8'h72:   hid = HID_DOWN;
      default: hid = HID_NONE;
    endcase
    return hid;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receives one 11-bit PS/2 frame (start, d0..d7, odd parity, stop).
// Ports:
//   clk_i, rst_i       : system clock, synchronous active-high reset
//   ps2_clk_i/_data_i  : raw asynchronous PS/2 pins
//   byte_o             : last good data byte
//   byte_valid_o       : 1-cycle pulse when byte_o holds a freshly checked byte
//   frame_err_o        : 1-cycle pulse on bad start/parity/stop or inter-edge timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W       = 4;

  // [0],[1] synchronise, [2] holds the previous synchronised level
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             fall_q, fall_d;
  logic [9:0]       shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [10:0]      frame_c;
  logic             frame_ok_c;

  // Incoming bit enters at the top; after 11 edges frame_c[0] is the start bit
  assign frame_c    = {data_sync_q[1], shift_q};
  assign frame_ok_c = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk_i};
    data_sync_d  = {data_sync_q[0], ps2_data_i};
    fall_d       = clk_sync_q[2] & ~clk_sync_q[1];
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall_q) begin
      tmo_d   = '0;
      shift_d = frame_c[10:1];
      if (bit_cnt_q == CNT_W'(PS2_FRAME_BITS - 1)) begin
        bit_cnt_d = '0;
        if (frame_ok_c) begin
          byte_valid_d = 1'b1;
          byte_d       = frame_c[8:1];
        end else begin
          frame_err_d  = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (bit_cnt_q != '0) begin
      // Abandon a frame whose clock has stalled mid-byte
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        tmo_d       = '0;
        bit_cnt_d   = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      fall_q       <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      fall_q       <= fall_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: PS/2 scan code set 2 keyboard to HID keycode bus.
// Ports:
//   Clk, Reset         : system clock, synchronous active-high reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 pins
//   keycode            : HID usage of the most recent still-held mapped key, 0x00 if none
//   key_press          : 1-cycle pulse when a mapped make code updates keycode
//   frame_err          : 1-cycle pulse on a malformed or timed-out frame
// Build option: define PS2_TYPEMATIC_FILTER_EN to suppress key_press for an
// auto-repeated make of the key already held.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_press,
  output logic       frame_err
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;

  scan_state_t state_q, state_d;
  logic [7:0]  keycode_q, keycode_d;
  logic        key_press_q, key_press_d;
  logic        make_c, brk_c;
  logic [7:0]  hid_c;

  ps2_rx_frame #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  // Scan-code FSM and held-key register
  always_comb begin
    state_d     = state_q;
    keycode_d   = keycode_q;
    key_press_d = 1'b0;
    make_c      = 1'b0;
    brk_c       = 1'b0;
    hid_c       = HID_NONE;

    if (rx_err) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_d = S_EXT;
          end else if (rx_byte == SC_BRK) begin
            state_d = S_BRK;
          end else begin
            make_c = 1'b1;
            hid_c  = xlat_base(rx_byte);
          end
        end
        S_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
            make_c  = 1'b1;
            hid_c   = xlat_ext(rx_byte);
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          brk_c   = 1'b1;
          hid_c   = xlat_base(rx_byte);
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          brk_c   = 1'b1;
          hid_c   = xlat_ext(rx_byte);
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (make_c && (hid_c != HID_NONE)) begin
      keycode_d = hid_c;
`ifdef PS2_TYPEMATIC_FILTER_EN
      key_press_d = (hid_c != keycode_q);
`else
      key_press_d = 1'b1;
`endif
    end

    // Only releasing the key that is currently shown clears the bus
    if (brk_c && (hid_c != HID_NONE) && (hid_c == keycode_q)) begin
      keycode_d = HID_NONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      keycode_q   <= HID_NONE;
      key_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      keycode_q   <= keycode_d;
      key_press_q <= key_press_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_press = key_press_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Testbench for ps2_keycode_decoder: directed PS/2 frames, expected output
// events queued by the stimulus and matched by a concurrent monitor.
module tb_ps2_keycode_decoder;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_press;
  logic       frame_err;

  typedef struct packed {
    logic       kp;
    logic       fe;
    logic [7:0] kc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #10 clk = ~clk;

  ps2_keycode_decoder dut (
    .Clk       (clk),
    .Reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_press (key_press),
    .frame_err (frame_err)
  );

  task automatic expect_ev(input logic kp, input logic fe, input logic [7:0] kc);
    ev_t e;
    e.kp = kp;
    e.fe = fe;
    e.kc = kc;
    exp_q.push_back(e);
  endtask

  // An event is any cycle with a pulse or a keycode change
  task automatic monitor();
    logic [7:0] prev_kc;
    ev_t        e;
    prev_kc = 8'h00;
    forever begin
      @(negedge clk);
      if (key_press || frame_err || (keycode !== prev_kc)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kp=%0b fe=%0b kc=%02h, required no event at %0t",
                   key_press, frame_err, keycode, $time);
        end else begin
          e = exp_q.pop_front();
          if (key_press !== e.kp || frame_err !== e.fe || keycode !== e.kc) begin
            errors++;
            $display("FAIL event: got kp=%0b fe=%0b kc=%02h, required kp=%0b fe=%0b kc=%02h at %0t",
                     key_press, frame_err, keycode, e.kp, e.fe, e.kc, $time);
          end
        end
      end
      prev_kc = keycode;
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checks++;
    if (keycode !== 8'h00) begin
      errors++;
      $display("FAIL reset_keycode: got %02h, required 00", keycode);
    end
    checks++;
    if (key_press !== 1'b0) begin
      errors++;
      $display("FAIL reset_key_press: got %0b, required 0", key_press);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_err: got %0b, required 0", frame_err);
    end

    fork
      monitor();
    join_none

    // A make then break
    expect_ev(1, 0, 8'h04); send(8'h1C);
    expect_ev(0, 0, 8'h00); send(8'hF0); send(8'h1C);

    // Extended up make then break
    expect_ev(1, 0, 8'h52); send(8'hE0); send(8'h75);
    expect_ev(0, 0, 8'h00); send(8'hE0); send(8'hF0); send(8'h75);

    // A, then D held; releasing A leaves D
    expect_ev(1, 0, 8'h04); send(8'h1C);
    expect_ev(1, 0, 8'h07); send(8'h23);
    send(8'hF0); send(8'h1C);
    expect_ev(0, 0, 8'h00); send(8'hF0); send(8'h23);

    // W held, corrupted parity keeps it, then normal release
    expect_ev(1, 0, 8'h1A); send(8'h1D);
    expect_ev(0, 1, 8'h1A); send_frame(8'h1D, 1'b1, 1'b0);
    expect_ev(0, 0, 8'h00); send(8'hF0); send(8'h1D);

    // Bad stop after E0 must drop the extended prefix
    send(8'hE0);
    expect_ev(0, 1, 8'h00); send_frame(8'h75, 1'b0, 1'b1);
    expect_ev(1, 0, 8'h04); send(8'h1C);
    expect_ev(0, 0, 8'h00); send(8'hF0); send(8'h1C);

    // Stalled frame times out, next frame decodes
    expect_ev(0, 1, 8'h00);
    send_partial(5);
    repeat (12500) @(negedge clk);
    expect_ev(1, 0, 8'h07); send(8'h23);

    // Reset mid-frame, then a fresh S; unmapped make ignored
    expect_ev(1, 0, 8'h04); send(8'h1C);
    send_partial(4);
    expect_ev(0, 0, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    expect_ev(1, 0, 8'h16); send(8'h1B);
    send(8'h15);

    // Typematic repeats of A
    expect_ev(1, 0, 8'h04); send(8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
    expect_ev(1, 0, 8'h04);
    expect_ev(1, 0, 8'h04);
`endif
    send(8'h1C);
    send(8'h1C);

    repeat (200) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
